// File: rtl/poci_bus_xbar.sv
// POCI (APB-style) fabric: one master to NSLAVE slaves through an address map, with a
// default slave for unmapped accesses, a wait-state watchdog and error capture.
module poci_bus_xbar #(
  parameter int unsigned            NSLAVE  = 4,
  parameter int unsigned            DATA_W  = 32,
  parameter int unsigned            DEC_LSB = 12,
  parameter logic [NSLAVE*32-1:0]   BASE    = {32'h8000_3000, 32'h8000_2000,
                                               32'h8000_1000, 32'h8000_0000},
  parameter int unsigned            TIMEOUT = 255
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     m_psel,
  input  logic                     m_penable,
  input  logic                     m_pwrite,
  input  logic [31:0]              m_paddr,
  input  logic [DATA_W-1:0]        m_pwdata,
  output logic [DATA_W-1:0]        m_prdata,
  output logic                     m_pready,
  output logic                     m_pslverr,
  output logic [NSLAVE-1:0]        s_psel,
  output logic                     s_penable,
  output logic                     s_pwrite,
  output logic [31:0]              s_paddr,
  output logic [DATA_W-1:0]        s_pwdata,
  input  logic [NSLAVE*DATA_W-1:0] s_prdata,
  input  logic [NSLAVE-1:0]        s_pready,
  input  logic [NSLAVE-1:0]        s_pslverr,
  output logic                     err_irq,
  output logic [7:0]               err_cnt,
  output logic [31:0]              err_addr
);

  localparam int unsigned IdxW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned TagW = 32 - DEC_LSB;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d, phase;
  logic [IdxW-1:0]   hit_idx, sel_q;
  logic              hit_miss, sel_miss_q;
  logic [7:0]        wait_q;
  logic              timeout, complete, err_evt;
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;

  assign s_penable = m_penable;
  assign s_pwrite  = m_pwrite;
  assign s_paddr   = m_paddr;
  assign s_pwdata  = m_pwdata;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_miss = 1'b1;
    hit_idx  = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (m_paddr[31:DEC_LSB] == BASE[32*i+DEC_LSB +: TagW]) begin
        hit_miss = 1'b0;
        hit_idx  = IdxW'(i);
      end
    end
  end

  // SETUP is decoded straight from the master so the select can assert in that same cycle.
  always_comb begin
    phase = StIdle;
    if (state_q == StAccess) begin
      phase = StAccess;
    end else if (m_psel && !m_penable) begin
      phase = StSetup;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (phase == StSetup) begin
      state_d = StAccess;
    end else if (phase == StAccess && !m_pready) begin
      state_d = StAccess;
    end
  end

  assign sel_ready = s_pready[sel_q];
  assign sel_err   = s_pslverr[sel_q];
  assign sel_rdata = s_prdata[DATA_W*sel_q +: DATA_W];

  assign timeout = (TIMEOUT != 0) && (phase == StAccess) && !sel_miss_q &&
                   (wait_q == 8'(TIMEOUT));

  always_comb begin
    s_psel    = '0;
    m_pready  = 1'b1;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    if (presetn) begin
      if (phase == StSetup) begin
        if (!hit_miss) s_psel[hit_idx] = 1'b1;
      end else if (phase == StAccess) begin
        if (sel_miss_q || timeout) begin
          m_pslverr = 1'b1;
        end else begin
          s_psel[sel_q] = 1'b1;
          m_pready      = sel_ready;
          m_pslverr     = sel_err;
          m_prdata      = sel_rdata;
        end
      end
    end
  end

  assign complete = (phase == StAccess) && m_pready;
  assign err_evt  = complete && m_pslverr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      sel_miss_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q <= state_d;
      if (phase == StSetup) begin
        sel_q      <= hit_idx;
        sel_miss_q <= hit_miss;
        wait_q     <= '0;
      end else if (phase == StAccess) begin
        if (!sel_miss_q && !sel_ready && !timeout && wait_q != 8'hFF) begin
          wait_q <= wait_q + 8'd1;
        end
      end else begin
        wait_q <= '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_irq  <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      err_irq <= err_evt;
      if (err_evt) begin
        err_addr <= m_paddr;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_poci_bus_xbar.sv
// Randomized bench for poci_bus_xbar; expected responses come from a transfer-level model
// (target lookup, wait/timeout length, saturating error bookkeeping).
module tb_poci_bus_xbar;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [NS*32-1:0] BASES = {32'h8000_3000, 32'h8000_2000,
                                        32'h8000_1000, 32'h8000_0000};

  logic              pclk = 1'b0;
  logic              presetn;
  logic              m_psel, m_penable, m_pwrite;
  logic [31:0]       m_paddr;
  logic [DW-1:0]     m_pwdata, m_prdata;
  logic              m_pready, m_pslverr;
  logic [NS-1:0]     s_psel;
  logic              s_penable, s_pwrite;
  logic [31:0]       s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic [NS*DW-1:0]  s_prdata;
  logic [NS-1:0]     s_pready, s_pslverr;
  logic              err_irq;
  logic [7:0]        err_cnt;
  logic [31:0]       err_addr;

  always #5 pclk = ~pclk;

  poci_bus_xbar #(
    .NSLAVE  (NS),
    .DATA_W  (DW),
    .DEC_LSB (12),
    .BASE    (BASES),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_paddr   (s_paddr),
    .s_pwdata  (s_pwdata),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr),
    .err_irq   (err_irq),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_addr = '0;
  bit          pend_irq = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int target_of(input logic [31:0] a);
    logic [NS*32-1:0] b;
    b = BASES;
    for (int i = 0; i < NS; i++) begin
      if (a[31:12] == b[32*i+12 +: 20]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr(input bit mapped);
    if (mapped) return {20'h80000 + 20'($urandom_range(0, NS - 1)), 12'($urandom)};
    return {4'h9, 28'($urandom)};
  endfunction

  task automatic check_err_regs();
    check_eq("err_irq", 32'(err_irq), 32'(pend_irq));
    check_eq("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    check_eq("err_addr", err_addr, exp_addr);
    pend_irq = 1'b0;
  endtask

  // One complete transfer; addr_acc is what the master drives during ACCESS.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] addr_acc,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int w,
                      input bit serr);
    int          tgt, exp_len, k;
    bit          exp_err, done;
    logic [31:0] exp_data, onehot, exp_sel;
    tgt = target_of(addr);
    onehot = (tgt >= 0) ? (32'd1 << tgt) : 32'd0;
    if (tgt < 0) begin
      exp_len = 1; exp_err = 1'b1; exp_data = '0;
    end else if (w >= TO) begin
      exp_len = TO + 1; exp_err = 1'b1; exp_data = '0;
    end else begin
      exp_len = w + 1; exp_err = serr; exp_data = rdata;
    end

    @(negedge pclk);
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr; m_pwdata = wdata;
    s_pready = '1;
    for (int i = 0; i < NS; i++) begin
      s_prdata[DW*i +: DW] = $urandom;
      s_pslverr[i]         = 1'($urandom_range(0, 1));
    end
    if (tgt >= 0) begin
      s_prdata[DW*tgt +: DW] = rdata;
      s_pslverr[tgt]         = serr;
      s_pready[tgt]          = 1'b0;
    end
    #1;
    check_err_regs();
    check_eq("setup_psel", 32'(s_psel), onehot);
    check_eq("setup_pwdata", s_pwdata, wdata);
    check_eq("setup_pready", 32'(m_pready), 32'd1);

    k = 0; done = 1'b0;
    while (!done && k < TO + 8) begin
      @(negedge pclk);
      k++;
      m_penable = 1'b1; m_paddr = addr_acc;
      if (tgt >= 0) s_pready[tgt] = (k > w);
      #1;
      exp_sel = (w >= TO && k == TO + 1) ? 32'd0 : onehot;
      check_eq("access_psel", 32'(s_psel), exp_sel);
      if (m_pready) done = 1'b1;
    end
    check_eq("access_len", 32'(k), 32'(exp_len));
    check_eq("pslverr", 32'(m_pslverr), 32'(exp_err));
    check_eq("prdata", m_prdata, exp_data);
    if (exp_err) begin
      pend_irq = 1'b1;
      if (exp_cnt < 255) exp_cnt++;
      exp_addr = addr_acc;
    end
  endtask

  task automatic idle(input bit stray);
    @(negedge pclk);
    m_psel = 1'b0; m_penable = stray; s_pready = '1;
    #1;
    check_err_regs();
    check_eq("idle_psel", 32'(s_psel), 32'd0);
    check_eq("idle_pready", 32'(m_pready), 32'd1);
    check_eq("idle_pslverr", 32'(m_pslverr), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    presetn = 1'b0;
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 32'h8000_0000;
    m_pwdata = '0; s_prdata = '0; s_pready = '1; s_pslverr = '0;
    repeat (2) @(negedge pclk);
    #1;
    check_eq("rst_psel", 32'(s_psel), 32'd0);
    check_eq("rst_pready", 32'(m_pready), 32'd1);
    check_eq("rst_prdata", m_prdata, 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_err_addr", err_addr, 32'd0);
    check_eq("rst_err_irq", 32'(err_irq), 32'd0);
    @(negedge pclk);
    m_psel = 1'b0;
    presetn = 1'b1;

    xfer(1'b1, 32'h8000_2004, 32'h8000_2004, 32'h1234_5678, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h8000_3010, 32'h8000_3010, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    xfer(1'b0, 32'h9000_0000, 32'h9000_0000, 32'h0, 32'h0, 0, 1'b0);
    idle(1'b0);
    xfer(1'b0, 32'h8000_1000, 32'h8000_1000, 32'h0, 32'h5555_AAAA, 10, 1'b0);
    xfer(1'b0, 32'h8000_1008, 32'h8000_1008, 32'h0, 32'h1111_2222, TO, 1'b0);
    xfer(1'b0, 32'h8000_0000, 32'h8000_1000, 32'h0, 32'h0BAD_BEEF, 2, 1'b0);
    idle(1'b1);

    for (int n = 0; n < 200; n++) begin
      a = rand_addr($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 7) == 0) ? rand_addr(1'b1) : a;
      xfer(1'($urandom_range(0, 1)), a, b, $urandom, $urandom, $urandom_range(0, 6),
           $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle(1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 300; n++) begin
      a = rand_addr(1'b0);
      xfer(1'b0, a, a, 32'h0, 32'h0, 0, 1'b0);
    end
    idle(1'b0);

    // Reset in the middle of a stalled ACCESS.
    @(negedge pclk);
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h8000_2000; s_pready = '0;
    repeat (2) begin
      @(negedge pclk);
      m_penable = 1'b1;
    end
    #2 presetn = 1'b0;
    #1;
    check_eq("midrst_psel", 32'(s_psel), 32'd0);
    check_eq("midrst_pready", 32'(m_pready), 32'd1);
    check_eq("midrst_pslverr", 32'(m_pslverr), 32'd0);
    check_eq("midrst_prdata", m_prdata, 32'd0);
    check_eq("midrst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge pclk);
    m_psel = 1'b0; m_penable = 1'b0; s_pready = '1;
    @(negedge pclk);
    presetn = 1'b1;
    exp_cnt = 0; exp_addr = '0; pend_irq = 1'b0;
    xfer(1'b0, 32'h8000_2010, 32'h8000_2010, 32'h0, 32'h7777_8888, 1, 1'b0);
    xfer(1'b1, 32'h8000_3000, 32'h8000_3000, 32'hDEAD_0001, 32'h0, 0, 1'b1);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
